// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall detection, MEM-stage redirect flushing,
// a small RUN/STALL/FLUSH state tracker and saturating debug counters.
module hazard_ctrl #(
   parameter int W  = 5,
   parameter int CW = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [W-1:0]  id_rs,
   input  logic [W-1:0]  id_rt,
   input  logic          id_uses_rt,
   input  logic          idex_MemRead,
   input  logic [W-1:0]  idex_rt,
   input  logic          mem_redirect,
   input  logic          cnt_clear,
   output logic          pc_write,
   output logic          ifid_write,
   output logic          idex_bubble,
   output logic          ifid_flush,
   output logic          idex_flush,
   output logic          exmem_flush,
   output logic [1:0]    state,
   output logic [CW-1:0] stall_count,
   output logic [CW-1:0] flush_count
);

   typedef enum logic [1:0] {
      RUN   = 2'b00,
      STALL = 2'b01,
      FLUSH = 2'b10
   } state_t;

   state_t cur_state, next_state;
   logic   lu;
   logic   stall_event;
   logic   rs_match;
   logic   rt_match;

   // Register 0 is hardwired to zero, so a load targeting it never creates a dependency.
   always_comb begin
      rs_match    = (idex_rt == id_rs);
      rt_match    = id_uses_rt && (idex_rt == id_rt);
      lu          = idex_MemRead && (idex_rt != '0) && (rs_match || rt_match);
      stall_event = lu && !mem_redirect;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cur_state <= RUN;
      end else begin
         cur_state <= next_state;
      end
   end

   always_comb begin
      next_state = cur_state;
      case (cur_state)
         RUN: begin
            if (mem_redirect)  next_state = FLUSH;
            else if (lu)       next_state = STALL;
            else               next_state = RUN;
         end
         STALL: begin
            if (mem_redirect)  next_state = FLUSH;
            else if (lu)       next_state = STALL;
            else               next_state = RUN;
         end
         FLUSH: begin
            if (mem_redirect)  next_state = FLUSH;
            else if (lu)       next_state = STALL;
            else               next_state = RUN;
         end
         default:              next_state = RUN;
      endcase
   end

   // Mealy controls; reset holds the front end frozen with a bubble into ID/EX.
   always_comb begin
      pc_write    = 1'b1;
      ifid_write  = 1'b1;
      idex_bubble = 1'b0;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      exmem_flush = 1'b0;
      if (reset) begin
         pc_write    = 1'b0;
         ifid_write  = 1'b0;
         idex_bubble = 1'b1;
      end else if (mem_redirect) begin
         ifid_flush  = 1'b1;
         idex_flush  = 1'b1;
         exmem_flush = 1'b1;
      end else if (lu) begin
         pc_write    = 1'b0;
         ifid_write  = 1'b0;
         idex_bubble = 1'b1;
      end
   end

   // A clear wins over an increment in the same cycle; counters stick at all-ones.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_count <= '0;
         flush_count <= '0;
      end else if (cnt_clear) begin
         stall_count <= '0;
         flush_count <= '0;
      end else begin
         if (stall_event && (stall_count != '1)) begin
            stall_count <= stall_count + CW'(1);
         end
         if (mem_redirect && (flush_count != '1)) begin
            flush_count <= flush_count + CW'(1);
         end
      end
   end

   assign state = cur_state;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed testbench for hazard_ctrl: a default-width instance plus a CW=2 instance
// sharing the same inputs so counter saturation is reachable in a few cycles.
module tb_hazard_ctrl;

   logic        clk;
   logic        reset;
   logic [4:0]  id_rs, id_rt, idex_rt;
   logic        id_uses_rt, idex_MemRead, mem_redirect, cnt_clear;
   logic        pc_write, ifid_write, idex_bubble, ifid_flush, idex_flush, exmem_flush;
   logic [1:0]  state;
   logic [15:0] stall_count, flush_count;
   logic        sm_pc_write, sm_ifid_write, sm_idex_bubble;
   logic        sm_ifid_flush, sm_idex_flush, sm_exmem_flush;
   logic [1:0]  sm_state;
   logic [1:0]  sm_stall_count, sm_flush_count;

   int vectors;
   int miscompares;

   hazard_ctrl dut (
      .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
      .idex_MemRead(idex_MemRead), .idex_rt(idex_rt), .mem_redirect(mem_redirect),
      .cnt_clear(cnt_clear), .pc_write(pc_write), .ifid_write(ifid_write),
      .idex_bubble(idex_bubble), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
      .exmem_flush(exmem_flush), .state(state), .stall_count(stall_count),
      .flush_count(flush_count)
   );

   hazard_ctrl #(.W(5), .CW(2)) dut_small (
      .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
      .idex_MemRead(idex_MemRead), .idex_rt(idex_rt), .mem_redirect(mem_redirect),
      .cnt_clear(cnt_clear), .pc_write(sm_pc_write), .ifid_write(sm_ifid_write),
      .idex_bubble(sm_idex_bubble), .ifid_flush(sm_ifid_flush), .idex_flush(sm_idex_flush),
      .exmem_flush(sm_exmem_flush), .state(sm_state), .stall_count(sm_stall_count),
      .flush_count(sm_flush_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      vectors++;
      if (observed !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic applyStimulus(input logic [4:0] rs, input logic [4:0] rt, input logic uses_rt,
                                input logic mem_read, input logic [4:0] ex_rt,
                                input logic redirect, input logic clear);
      id_rs        = rs;
      id_rt        = rt;
      id_uses_rt   = uses_rt;
      idex_MemRead = mem_read;
      idex_rt      = ex_rt;
      mem_redirect = redirect;
      cnt_clear    = clear;
   endtask

   task automatic checkComb(input string tag, input logic exp_pc, input logic exp_ifid,
                            input logic exp_bubble, input logic exp_flush);
      checkOutput({tag, ".pc_write"},    32'(pc_write),    32'(exp_pc));
      checkOutput({tag, ".ifid_write"},  32'(ifid_write),  32'(exp_ifid));
      checkOutput({tag, ".idex_bubble"}, 32'(idex_bubble), 32'(exp_bubble));
      checkOutput({tag, ".ifid_flush"},  32'(ifid_flush),  32'(exp_flush));
      checkOutput({tag, ".idex_flush"},  32'(idex_flush),  32'(exp_flush));
      checkOutput({tag, ".exmem_flush"}, 32'(exmem_flush), 32'(exp_flush));
   endtask

   task automatic checkRegs(input string tag, input int exp_state, input int exp_sc,
                            input int exp_fc, input int exp_ssc, input int exp_sfc);
      checkOutput({tag, ".state"},       32'(state),          exp_state);
      checkOutput({tag, ".stall_count"}, 32'(stall_count),    exp_sc);
      checkOutput({tag, ".flush_count"}, 32'(flush_count),    exp_fc);
      checkOutput({tag, ".sm_stall"},    32'(sm_stall_count), exp_ssc);
      checkOutput({tag, ".sm_flush"},    32'(sm_flush_count), exp_sfc);
   endtask

   // One cycle: drive just after a rising edge, check Mealy outputs mid-cycle,
   // then check registered state just after the next rising edge.
   task automatic step(input string tag, input logic [4:0] rs, input logic [4:0] rt,
                       input logic uses_rt, input logic mem_read, input logic [4:0] ex_rt,
                       input logic redirect, input logic clear,
                       input logic exp_pc, input logic exp_bubble, input logic exp_flush,
                       input int exp_state, input int exp_sc, input int exp_fc,
                       input int exp_ssc, input int exp_sfc);
      applyStimulus(rs, rt, uses_rt, mem_read, ex_rt, redirect, clear);
      #2;
      checkComb(tag, exp_pc, exp_pc, exp_bubble, exp_flush);
      @(posedge clk);
      #1;
      checkRegs(tag, exp_state, exp_sc, exp_fc, exp_ssc, exp_sfc);
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      reset       = 1'b1;
      applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
      #3;
      checkComb("reset", 1'b0, 1'b0, 1'b1, 1'b0);
      checkRegs("reset", 0, 0, 0, 0, 0);
      #9 reset = 1'b0;
      @(posedge clk);
      #1;

      //    tag         rs    rt    use   mrd   ex_rt redir clr   pc    bub   fl    st sc fc ssc sfc
      step("idle",     5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 0, 0, 0);
      step("lu_rs",    5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1, 1, 0, 1, 0);
      step("unstall",  5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1, 0, 1, 0);
      step("reg0",     5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1, 0, 1, 0);
      step("rt_unused",5'd3, 5'd9, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1, 0, 1, 0);
      step("rt_used",  5'd3, 5'd9, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1, 2, 0, 2, 0);
      step("no_load",  5'd9, 5'd9, 1'b1, 1'b0, 5'd9, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 2, 0, 2, 0);
      step("clear",    5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 0, 0, 0);
      step("redir_lu", 5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2, 0, 1, 0, 1);
      step("redir2",   5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2, 0, 2, 0, 2);
      step("fl_to_st", 5'd4, 5'd0, 1'b0, 1'b1, 5'd4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1, 1, 2, 1, 2);
      step("st_to_fl", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2, 1, 3, 1, 3);
      step("fl_to_run",5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1, 3, 1, 3);
      step("fl_sat",   5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2, 1, 4, 1, 3);

      // Back-to-back load-use stalls push the narrow stall counter into saturation.
      for (int i = 0; i < 4; i++) begin
         step("st_sat", 5'd7, 5'd0, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
              1, 2 + i, 4, (i == 0) ? 2 : 3, 3);
      end
      step("clr_stall",5'd7, 5'd0, 1'b0, 1'b1, 5'd7, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1, 0, 0, 0, 0);
      step("pre_rst",  5'd6, 5'd0, 1'b0, 1'b1, 5'd6, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1, 1, 0, 1, 0);

      // Asynchronous reset pulse landing between edges while stalled.
      applyStimulus(5'd6, 5'd0, 1'b0, 1'b1, 5'd6, 1'b1, 1'b0);
      #2 reset = 1'b1;
      #1;
      checkComb("mid_rst", 1'b0, 1'b0, 1'b1, 1'b0);
      checkRegs("mid_rst", 0, 0, 0, 0, 0);
      #2 reset = 1'b0;
      applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
      #1;
      checkComb("post_rst", 1'b1, 1'b1, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      checkRegs("post_rst", 0, 0, 0, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #20000;
      $display("[TB] FAIL timeout: got running, expected finished");
      $fatal(1, "[TB] timeout");
   end

endmodule
